// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - decode stage: IF/ID register, 8x16 register file, load-use hazard, ID/EX register
module id_decode_stage #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 12,
   parameter int NREG   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   if_pc,
   input  logic [15:0]       if_inst,
   input  logic              if_valid,
   input  logic              flush,
   input  logic              stall_in,
   input  logic              wb_en,
   input  logic [2:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              pc_stall,
   output logic              id_valid,
   output logic [PC_W-1:0]   id_pc,
   output logic [3:0]        id_opcode,
   output logic [2:0]        id_rd,
   output logic [DATA_W-1:0] id_rs_data,
   output logic [DATA_W-1:0] id_rt_data,
   output logic [DATA_W-1:0] id_imm,
   output logic [PC_W-1:0]   id_jtarget,
   output logic [6:0]        id_ctrl
);

   // id_ctrl bit positions: {reg_write, mem_read, mem_write, branch, jump, alu_imm, halt}
   localparam int CTRL_MEM_READ = 5;

   logic              ifid_valid;
   logic [PC_W-1:0]   ifid_pc;
   logic [15:0]       ifid_inst;

   logic [DATA_W-1:0] rf [NREG];

   logic [3:0]        opcode;
   logic [2:0]        rd_addr;
   logic [2:0]        rs_addr;
   logic [2:0]        rt_addr;
   logic [6:0]        dec_ctrl;
   logic              uses_rs;
   logic              uses_rt;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic [DATA_W-1:0] imm;
   logic              hazard;

   assign opcode  = ifid_inst[15:12];
   assign rd_addr = ifid_inst[11:9];
   assign rs_addr = ifid_inst[8:6];
   assign rt_addr = ifid_inst[5:3];
   assign imm     = {{(DATA_W-6){ifid_inst[5]}}, ifid_inst[5:0]};

   // Control decode and source-usage flags for the instruction held in IF/ID
   always_comb begin
      dec_ctrl = 7'b0000000;
      uses_rs  = 1'b0;
      uses_rt  = 1'b0;
      case (opcode)
         4'h1, 4'h2, 4'h3, 4'h4: begin
            dec_ctrl = 7'b1000000;
            uses_rs  = 1'b1;
            uses_rt  = 1'b1;
         end
         4'h5: begin
            dec_ctrl = 7'b1000010;
            uses_rs  = 1'b1;
         end
         4'h6: begin
            dec_ctrl = 7'b1100010;
            uses_rs  = 1'b1;
         end
         4'h7: begin
            dec_ctrl = 7'b0010010;
            uses_rs  = 1'b1;
            uses_rt  = 1'b1;
         end
         4'h8: begin
            dec_ctrl = 7'b0001000;
            uses_rs  = 1'b1;
            uses_rt  = 1'b1;
         end
         4'h9:    dec_ctrl = 7'b0000100;
         4'hF:    dec_ctrl = 7'b0000001;
         default: dec_ctrl = 7'b0000000;
      endcase
   end

   // R0 is hardwired zero; a write landing this cycle is forwarded to the read
   assign rs_data = (rs_addr == 3'd0) ? '0 :
                    (wb_en && wb_addr == rs_addr) ? wb_data : rf[rs_addr];
   assign rt_data = (rt_addr == 3'd0) ? '0 :
                    (wb_en && wb_addr == rt_addr) ? wb_data : rf[rt_addr];

   // A load in ID/EX cannot forward its data in time to a dependent instruction in IF/ID
   assign hazard = ifid_valid && id_valid && id_ctrl[CTRL_MEM_READ] && (id_rd != 3'd0) &&
                   ((uses_rs && id_rd == rs_addr) || (uses_rt && id_rd == rt_addr));

   assign pc_stall = hazard | stall_in;

   // Register file write port; writes to R0 are dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_en && wb_addr != 3'd0) begin
         rf[wb_addr] <= wb_data;
      end
   end

   // IF/ID register: flush kills, stall or hazard holds, otherwise capture fetch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifid_valid <= 1'b0;
         ifid_pc    <= '0;
         ifid_inst  <= '0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
      end else if (!stall_in && !hazard) begin
         ifid_valid <= if_valid;
         ifid_pc    <= if_pc;
         ifid_inst  <= if_inst;
      end
   end

   // ID/EX register: flush kills, stall holds, hazard inserts a bubble, otherwise load decode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_valid   <= 1'b0;
         id_pc      <= '0;
         id_opcode  <= '0;
         id_rd      <= '0;
         id_rs_data <= '0;
         id_rt_data <= '0;
         id_imm     <= '0;
         id_jtarget <= '0;
         id_ctrl    <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
         id_ctrl  <= '0;
      end else if (!stall_in) begin
         if (hazard) begin
            id_valid <= 1'b0;
            id_ctrl  <= '0;
         end else begin
            id_valid   <= ifid_valid;
            id_ctrl    <= ifid_valid ? dec_ctrl : 7'b0000000;
            id_pc      <= ifid_pc;
            id_opcode  <= opcode;
            id_rd      <= rd_addr;
            id_rs_data <= rs_data;
            id_rt_data <= rt_data;
            id_imm     <= imm;
            id_jtarget <= ifid_inst[PC_W-1:0];
         end
      end
   end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Decode stage directly downstream of the fetch stage. Consumes the fetched 16-bit instruction and its PC, holds them in an IF/ID register, and decodes fields and control signals.
- Reads operands from an internal 8x16 register file, which is written by the writeback port.
- Detects load-use hazards and drives an ID/EX register that feeds execute.

Parameters:
- DATA_W, 16, register/operand width.
- PC_W, 12, PC and jump-target width.
- NREG, 8, register count (3-bit specifiers).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- if_pc  in  12  PC accompanying if_inst (fetch nextPC).
- if_inst  in  16  instruction word from fetch.
- if_valid  in  1  if_pc/if_inst hold a real instruction.
- flush  in  1  kill IF/ID and ID/EX contents (taken branch/jump).
- stall_in  in  1  downstream stall; freeze both registers.
- wb_en  in  1  register-file write enable.
- wb_addr  in  3  write register.
- wb_data  in  16  write data.
- pc_stall  out  1  hold fetch PC; = hazard | stall_in, combinational.
- id_valid  out  1  ID/EX contents valid.
- id_pc  out  12  PC of decoded instruction.
- id_opcode  out  4  inst[15:12].
- id_rd  out  3  inst[11:9].
- id_rs_data  out  16  RF[inst[8:6]].
- id_rt_data  out  16  RF[inst[5:3]].
- id_imm  out  16  sign-extended inst[5:0].
- id_jtarget  out  12  inst[11:0].
- id_ctrl  out  7  {reg_write, mem_read, mem_write, branch, jump, alu_imm, halt}.

Behaviour:
- Reset (rst=0, async): IF/ID valid=0, ID/EX valid=0, and all id_* outputs 0. All RF entries 0. pc_stall follows its equation with id_valid=0.
- Opcodes and id_ctrl bits:
  - 0 NOP: none.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: reg_write.
  - 5 ADDI: reg_write, alu_imm.
  - 6 LD: reg_write, mem_read, alu_imm.
  - 7 ST: mem_write, alu_imm.
  - 8 BEQ: branch.
  - 9 JMP: jump.
  - F HALT: halt.
  - A-E: decode as NOP (ctrl=0), id_valid still propagates.
- Latency: the instruction on if_* at edge N is captured in IF/ID. It is decoded combinationally during cycle N+1 and appears on id_* after edge N+1. With no stalls the throughput is one per cycle.
- Register file:
  - R0 always reads 0, and writes to R0 are ignored.
  - Write happens at posedge when wb_en=1.
  - Same-cycle bypass: if wb_en and wb_addr==source (nonzero), the read returns wb_data.
- Hazard: asserted when all of the following hold:
  - IF/ID valid;
  - id_valid and id_ctrl.mem_read;
  - id_rd≠0;
  - id_rd equals a used source of the IF/ID instruction. Used sources: rs for opcodes 1-8; rt for opcodes 1-4, 7, 8.
- Per-edge priority, highest first:
  1. flush: IF/ID valid←0, ID/EX valid←0, other fields don't-care.
  2. stall_in: both registers hold.
  3. hazard: IF/ID holds; ID/EX←bubble (valid=0, ctrl=0).
  4. Otherwise: IF/ID←{if_pc, if_inst, if_valid}; ID/EX←decode(IF/ID), valid=IF/ID valid.
- Invalid instructions load ctrl=0, so they can never assert reg_write/mem_write downstream.
- flush concurrent with hazard or stall_in: flush wins. pc_stall may still be 1 that cycle, and fetch handles redirect priority.
- Reset mid-operation: immediately clears as above. The first edge after rst deasserts captures if_* normally.

Test Plan:
- Reset → all id_* 0, id_valid=0. RF read of R1..R7 returns 0.
- Write R2=0x1234 (wb), then inst 0x1290 (ADD R1,R2,R2), pc=0x005 → two edges later: id_opcode=1, id_rd=1, id_rs_data=id_rt_data=0x1234, id_pc=0x005, reg_write=1.
- Bypass: wb_en=1, R3←0xBEEF in the same cycle the ADDI R4,R3,-1 (0x58FF) is decoded → id_rs_data=0xBEEF, id_imm=0xFFFF, alu_imm=1.
- Load-use: LD R1 (0x6200) followed by ADD R5,R1,R0 (0x1A40) → pc_stall=1 for exactly one cycle, one bubble (id_valid=0). The ADD then issues with ctrl reg_write=1.
- flush asserted while stall_in=1 and IF/ID holds JMP 0x9ABC → next edge id_valid=0 and IF/ID valid=0; no jump ctrl emitted.
- Async reset asserted mid-stream between clock edges → outputs clear without a clock edge. Resume at pc=0x004 with NOP → id_valid=1, id_ctrl=0.
